// File: rtl/mult_cell_sequencer.sv
// mult_cell_sequencer: two-requester front end for a shared 3x16x16 multiply cell.
// Accepts one operand pair at a time, fires the cell for one cycle, waits
// CELL_LATENCY cycles, assembles the low 32 bits of a*b and holds the result
// until the consumer takes it.
// Optional feature: define MULT_CELL_SEQ_RR_EN for round-robin arbitration;
// otherwise requester 0 has fixed priority.
module mult_cell_sequencer #(
  parameter int CELL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_id,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  output logic        cell_en,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic        id_q, id_d;
  logic        gnt_id, hs;
`ifdef MULT_CELL_SEQ_RR_EN
  logic        ptr_q, ptr_d;
`endif

  // Combinational grant: a lone valid wins; a tie goes to the pointer or to requester 0
  always_comb begin
    gnt_id = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef MULT_CELL_SEQ_RR_EN
      gnt_id = ptr_q;
`else
      gnt_id = 1'b0;
`endif
    end else if (req1_valid) begin
      gnt_id = 1'b1;
    end
    // reset gates the handshake so ready stays low while the block is held
    hs = (state_q == IDLE) && !reset && (req0_valid || req1_valid);
  end

  // State and datapath registers; reset aborts any in-flight operation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      data_q  <= '0;
`ifdef MULT_CELL_SEQ_RR_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      data_q  <= data_d;
`ifdef MULT_CELL_SEQ_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // Next-state logic: IDLE -> ISSUE (one cycle) -> WAIT (CELL_LATENCY cycles) -> RESP
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt_q == 3'd0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, wait counter, result assembly, pointer update
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    id_d   = id_q;
    cnt_d  = cnt_q;
    data_d = data_q;
`ifdef MULT_CELL_SEQ_RR_EN
    ptr_d  = ptr_q;
`endif
    if (hs) begin
      a_d  = gnt_id ? req1_a : req0_a;
      b_d  = gnt_id ? req1_b : req0_b;
      id_d = gnt_id;
`ifdef MULT_CELL_SEQ_RR_EN
      ptr_d = ~gnt_id;
`endif
    end
    if (state_q == ISSUE) begin
      cnt_d = 3'(CELL_LATENCY - 1);
    end else if (state_q == WAIT) begin
      if (cnt_q == 3'd0) begin
        // a*b mod 2^32 = lo*lo + ((lo*hi + hi*lo) << 16); hi*hi only touches bits >= 32
        data_d = cell_p1 + ((cell_p2 + cell_p3) << 16);
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
    end
  end

  // Outputs: ready only in IDLE for the granted requester, cell fired only in ISSUE
  always_comb begin
    req0_ready = hs && !gnt_id && req0_valid;
    req1_ready = hs && gnt_id && req1_valid;
    cell_en    = (state_q == ISSUE);
    rsp_valid  = (state_q == RESP);
    cell_src1  = a_q;
    cell_src2  = b_q;
    rsp_data   = data_q;
    rsp_id     = id_q;
  end

endmodule
